// File: rtl/biquad_pkg.sv
// Shared constants and helpers for the time-multiplexed biquad section.
// Holds state encodings, accumulator sizing and the output round/saturate function.
package biquad_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMac  = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  localparam logic [2:0] MacLast = 3'd4;

  // Working width of sat_round; must exceed any accumulator it is given.
  localparam int unsigned SatMaxW = 128;

  function automatic int unsigned acc_width(input int unsigned bw, input int unsigned cw);
    return bw + cw + 3;
  endfunction

  // Round half up, arithmetic shift right by frac, clamp to signed outw bits.
  function automatic logic signed [SatMaxW-1:0] sat_round(
    input logic signed [SatMaxW-1:0] acc,
    input int unsigned               frac,
    input int unsigned               outw
  );
    logic signed [SatMaxW-1:0] one;
    logic signed [SatMaxW-1:0] rnd;
    logic signed [SatMaxW-1:0] max_v;
    logic signed [SatMaxW-1:0] min_v;
    one = {{(SatMaxW-1){1'b0}}, 1'b1};
    rnd = acc;
    if (frac > 0) begin
      rnd = (acc + (one <<< (frac - 1))) >>> frac;
    end
    max_v = (one <<< (outw - 1)) - one;
    min_v = -(one <<< (outw - 1));
    if (rnd > max_v) begin
      return max_v;
    end else if (rnd < min_v) begin
      return min_v;
    end
    return rnd;
  endfunction

endpackage

// File: rtl/biquad_mac.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
// Kept apart from the FSM so the multiplier can be pipelined independently.
module biquad_mac #(
  parameter int unsigned AW   = 32,
  parameter int unsigned BW   = 19,
  parameter int unsigned ACCW = 53
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [AW-1:0]   a,
  input  logic signed [BW-1:0]   b,
  output logic signed [ACCW-1:0] acc
);

  logic signed [AW+BW-1:0] prod;
  logic signed [ACCW-1:0]  acc_d;
  logic signed [ACCW-1:0]  acc_q;

  assign prod = a * b;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACCW'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/biquad_sos.sv
// Direct-form-I biquad sharing one multiplier: accept, five MAC cycles, then output.
// One result per accepted sample, six cycles after the accept edge.
module biquad_sos
  import biquad_pkg::*;
#(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned COEFW    = 18,
  parameter int unsigned FRAC     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BITWIDTH-1:0] sig_in,
  input  logic signed [COEFW-1:0]    b0,
  input  logic signed [COEFW-1:0]    b1,
  input  logic signed [COEFW-1:0]    b2,
  input  logic signed [COEFW-1:0]    a1,
  input  logic signed [COEFW-1:0]    a2,
  output logic                       out_valid,
  output logic signed [BITWIDTH-1:0] sig_out
);

  localparam int unsigned ACCW  = acc_width(BITWIDTH, COEFW);
  // One extra bit so that negating the most negative coefficient cannot overflow.
  localparam int unsigned MulBW = COEFW + 1;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic signed [BITWIDTH-1:0] x_q, x_d, x1_q, x1_d, x2_q, x2_d;
  logic signed [BITWIDTH-1:0] y1_q, y1_d, y2_q, y2_d;
  logic signed [BITWIDTH-1:0] sig_out_q, sig_out_d;
  logic signed [COEFW-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, a1_q, a1_d, a2_q, a2_d;
  logic out_valid_q, out_valid_d;

  logic                       mac_clr, mac_en;
  logic signed [BITWIDTH-1:0] mul_a;
  logic signed [MulBW-1:0]    mul_b;
  logic signed [ACCW-1:0]     acc;
  logic signed [SatMaxW-1:0]  y_wide;
  logic signed [BITWIDTH-1:0] y_sat;
  logic                       unused_y_hi;

  assign y_wide      = sat_round(SatMaxW'(acc), FRAC, BITWIDTH);
  assign y_sat       = y_wide[BITWIDTH-1:0];
  assign unused_y_hi = ^y_wide[SatMaxW-1:BITWIDTH];

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (cnt_q)
      3'd0: begin mul_a = x_q;  mul_b = MulBW'(b0_q);  end
      3'd1: begin mul_a = x1_q; mul_b = MulBW'(b1_q);  end
      3'd2: begin mul_a = x2_q; mul_b = MulBW'(b2_q);  end
      3'd3: begin mul_a = y1_q; mul_b = -MulBW'(a1_q); end
      3'd4: begin mul_a = y2_q; mul_b = -MulBW'(a2_q); end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    sig_out_d   = sig_out_q;
    out_valid_d = 1'b0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = sig_in;
          b0_d    = b0;
          b1_d    = b1;
          b2_d    = b2;
          a1_d    = a1;
          a2_d    = a2;
          cnt_d   = '0;
          mac_clr = 1'b1;
          state_d = StMac;
        end
      end
      StMac: begin
        mac_en = 1'b1;
        if (cnt_q == MacLast) begin
          state_d = StOut;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StOut: begin
        out_valid_d = 1'b1;
        sig_out_d   = y_sat;
        x2_d        = x1_q;
        x1_d        = x_q;
        y2_d        = y1_q;
        y1_d        = y_sat;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      x_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      sig_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      sig_out_q   <= sig_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  biquad_mac #(
    .AW   (BITWIDTH),
    .BW   (MulBW),
    .ACCW (ACCW)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (mul_a),
    .b     (mul_b),
    .acc   (acc)
  );

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign sig_out   = sig_out_q;

endmodule

// File: tb/tb_biquad_sos.sv
// Directed bench for biquad_sos: vector table plus handshake and mid-MAC reset sequences.
module tb_biquad_sos;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] sig_in;
  logic [31:0] sig_out;
  logic [17:0] b0, b1, b2, a1, a2;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    bit          rst;
    logic [31:0] x;
    logic [17:0] b0, b1, b2, a1, a2;
    logic [31:0] y;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  biquad_sos #(
    .BITWIDTH (32),
    .COEFW    (18),
    .FRAC     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sig_in    (sig_in),
    .b0        (b0),
    .b1        (b1),
    .b2        (b2),
    .a1        (a1),
    .a2        (a2),
    .out_valid (out_valid),
    .sig_out   (sig_out)
  );

  function automatic vec_t mk(input string name, input bit rst, input int x,
                              input int c0, input int c1, input int c2,
                              input int c3, input int c4, input int y);
    vec_t v;
    v.name = name;
    v.rst  = rst;
    v.x    = x;
    v.b0   = 18'(c0);
    v.b1   = 18'(c1);
    v.b2   = 18'(c2);
    v.a1   = 18'(c3);
    v.a2   = 18'(c4);
    v.y    = y;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_coefs(input logic [17:0] c0, input logic [17:0] c1, input logic [17:0] c2,
                           input logic [17:0] c3, input logic [17:0] c4);
    b0 = c0;
    b1 = c1;
    b2 = c2;
    a1 = c3;
    a2 = c4;
  endtask

  task automatic do_sample(input vec_t v);
    int waitc = 0;
    int lat   = 0;
    @(negedge clk);
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      check({v.name, "_ready_timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    sig_in   = v.x;
    set_coefs(v.b0, v.b1, v.b2, v.a1, v.a2);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble ports mid-MAC; only the values latched at accept may be used.
    sig_in = 32'hDEAD_BEEF;
    set_coefs(18'h1FFFF, 18'h2AAAA, 18'h15555, 18'h3FFFF, 18'h20000);
    while (!out_valid && lat < 15) begin
      @(negedge clk);
      lat++;
    end
    check({v.name, "_latency"}, lat, 32'd6);
    check({v.name, "_value"}, sig_out, v.y);
    check({v.name, "_ready_at_out"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen_valid;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sig_in   = '0;
    set_coefs('0, '0, '0, '0, '0);

    vecs[0]  = mk("pass_1000", 1, 1000, 65536, 0, 0, 0, 0, 1000);
    vecs[1]  = mk("pass_m7",   0, -7,   65536, 0, 0, 0, 0, -7);
    vecs[2]  = mk("half_p3",   0, 3,    32768, 0, 0, 0, 0, 2);
    vecs[3]  = mk("half_m3",   0, -3,   32768, 0, 0, 0, 0, -1);
    vecs[4]  = mk("delay_5",   1, 5,    0, 65536, 0, 0, 0, 0);
    vecs[5]  = mk("delay_7",   0, 7,    0, 65536, 0, 0, 0, 5);
    vecs[6]  = mk("delay_9",   0, 9,    0, 65536, 0, 0, 0, 7);
    vecs[7]  = mk("b2_11",     1, 11,   0, 0, 65536, 0, 0, 0);
    vecs[8]  = mk("b2_13",     0, 13,   0, 0, 65536, 0, 0, 0);
    vecs[9]  = mk("b2_15",     0, 15,   0, 0, 65536, 0, 0, 11);
    vecs[10] = mk("fb_0",      1, 1000, 65536, 0, 0, -32768, 0, 1000);
    vecs[11] = mk("fb_1",      0, 0,    65536, 0, 0, -32768, 0, 500);
    vecs[12] = mk("fb_2",      0, 0,    65536, 0, 0, -32768, 0, 250);
    vecs[13] = mk("fb_3",      0, 0,    65536, 0, 0, -32768, 0, 125);
    vecs[14] = mk("sat_pos",   1, 32'h7FFF_FFF0, 131071, 0, 0, 0, 0, 32'h7FFF_FFFF);
    vecs[15] = mk("sat_neg",   0, 32'h8000_0010, 131071, 0, 0, 0, 0, 32'h8000_0000);
    vecs[16] = mk("sat_y1",    0, 0,    0, 0, 0, -32768, 0, 32'hC000_0000);
    vecs[17] = mk("sat_y2",    0, 0,    0, 0, 0, 0, -65536, 32'h8000_0000);

    do_reset();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sig_out", sig_out, 32'd0);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].rst) do_reset();
      do_sample(vecs[i]);
    end

    // Continuous in_valid: accepts every 7 cycles, garbage coefficients while busy.
    do_reset();
    for (int t = 0; t < 21; t++) begin
      if (t > 0) @(negedge clk);
      check("hs_in_ready", 32'(in_ready), 32'((t % 7) == 0));
      check("hs_out_valid", 32'(out_valid), 32'(((t % 7) == 0) && (t > 0)));
      if ((t % 7) == 0 && t > 0) check("hs_value", sig_out, 32'(100 + t - 7));
      in_valid = 1'b1;
      sig_in   = 32'(100 + t);
      if ((t % 7) == 0) set_coefs(18'd65536, '0, '0, '0, '0);
      else set_coefs(18'h01234, 18'h2ABCD, 18'h3F00F, 18'h15555, 18'h20001);
    end
    in_valid = 1'b0;

    // Reset while the MAC counter sits at 2 discards the sample and clears history.
    do_reset();
    do_sample(mk("pre_rst", 0, 500, 65536, 0, 0, 0, 0, 500));
    @(negedge clk);
    in_valid = 1'b1;
    sig_in   = 32'd777;
    set_coefs('0, 18'd65536, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sig_out", sig_out, 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    check("mid_rst_no_out_valid", 32'(seen_valid), 32'd0);
    do_sample(mk("post_rst_hist", 0, 42, 0, 65536, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
